wb_commit_unit: RTL and testbench

Write-back commit stage that sits between the execute unit and the architectural-state update interface (PC/CSR/GPR write strobes consumed by the simulator bridge).
- Accepts retired-instruction results over a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one instruction per cycle, as registered write strobes plus address/data.
- Supports a halt input and a running commit counter for difftest/perf.

---
 rtl/wb_commit_pkg.sv | 22 ++
 rtl/commit_fifo.sv | 66 ++++++
 rtl/wb_commit_unit.sv | 121 ++++++++++++
 tb/tb_wb_commit_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared types and widths for the write-back commit stage.
package wb_commit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned GPR_AW = 5;
    localparam int unsigned CSR_AW = 12;

    // One retired instruction as held in the commit FIFO.
    typedef struct packed {
        logic [XLEN-1:0]   pc_next;
        logic              gpr_wen;
        logic [GPR_AW-1:0] gpr_waddr;
        logic [XLEN-1:0]   gpr_wdata;
        logic              csra_wen;
        logic [CSR_AW-1:0] csra_addr;
        logic [XLEN-1:0]   csra_wdata;
        logic              csrb_wen;
        logic [CSR_AW-1:0] csrb_addr;
        logic [XLEN-1:0]   csrb_wdata;
    } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit entries; only the pointers and count are reset.
module commit_fifo
    import wb_commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  commit_entry_t data_i,
    input  logic          pop_i,
    output commit_entry_t data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    commit_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail; contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: buffers retired instructions and drains one per cycle
// as registered architectural-state write strobes.
module wb_commit_unit
    import wb_commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc_next,
    input  logic              in_gpr_wen,
    input  logic [GPR_AW-1:0] in_gpr_waddr,
    input  logic [XLEN-1:0]   in_gpr_wdata,
    input  logic              in_csra_wen,
    input  logic [CSR_AW-1:0] in_csra_addr,
    input  logic [XLEN-1:0]   in_csra_wdata,
    input  logic              in_csrb_wen,
    input  logic [CSR_AW-1:0] in_csrb_addr,
    input  logic [XLEN-1:0]   in_csrb_wdata,
    input  logic              halt,
    output logic              pc_wen,
    output logic              csra_wen,
    output logic              csrb_wen,
    output logic              gpr_wen,
    output logic [XLEN-1:0]   new_pc,
    output logic [CSR_AW-1:0] CSR_waddra,
    output logic [XLEN-1:0]   new_CSRa,
    output logic [CSR_AW-1:0] CSR_waddrb,
    output logic [XLEN-1:0]   new_CSRb,
    output logic [GPR_AW-1:0] GPR_waddr,
    output logic [XLEN-1:0]   new_GPR,
    output logic [CNT_W-1:0]  commit_cnt
);

    commit_entry_t in_entry;
    commit_entry_t head;
    commit_entry_t out_q, out_d;
    logic          pc_wen_q, pc_wen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign pop      = ~fifo_empty & ~halt;

    // Enqueue sanitisation: x0 is never written, and port B wins a same-address CSR clash.
    always_comb begin
        in_entry            = '0;
        in_entry.pc_next    = in_pc_next;
        in_entry.gpr_wen    = in_gpr_wen & (in_gpr_waddr != '0);
        in_entry.gpr_waddr  = in_gpr_waddr;
        in_entry.gpr_wdata  = in_gpr_wdata;
        in_entry.csra_wen   = in_csra_wen & ~(in_csrb_wen & (in_csra_addr == in_csrb_addr));
        in_entry.csra_addr  = in_csra_addr;
        in_entry.csra_wdata = in_csra_wdata;
        in_entry.csrb_wen   = in_csrb_wen;
        in_entry.csrb_addr  = in_csrb_addr;
        in_entry.csrb_wdata = in_csrb_wdata;
    end

    commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .data_i  (in_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output next-state: strobes are single-cycle, address/data hold between commits.
    always_comb begin
        out_d          = out_q;
        out_d.gpr_wen  = 1'b0;
        out_d.csra_wen = 1'b0;
        out_d.csrb_wen = 1'b0;
        pc_wen_d       = 1'b0;
        cnt_d          = cnt_q;
        if (pop) begin
            out_d    = head;
            pc_wen_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Output and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            pc_wen_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            out_q    <= out_d;
            pc_wen_q <= pc_wen_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc_wen     = pc_wen_q;
    assign gpr_wen    = out_q.gpr_wen;
    assign csra_wen   = out_q.csra_wen;
    assign csrb_wen   = out_q.csrb_wen;
    assign new_pc     = out_q.pc_next;
    assign GPR_waddr  = out_q.gpr_waddr;
    assign new_GPR    = out_q.gpr_wdata;
    assign CSR_waddra = out_q.csra_addr;
    assign new_CSRa   = out_q.csra_wdata;
    assign CSR_waddrb = out_q.csrb_addr;
    assign new_CSRb   = out_q.csrb_wdata;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit.
module tb_wb_commit_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_next;
    logic        in_gpr_wen;
    logic [4:0]  in_gpr_waddr;
    logic [31:0] in_gpr_wdata;
    logic        in_csra_wen;
    logic [11:0] in_csra_addr;
    logic [31:0] in_csra_wdata;
    logic        in_csrb_wen;
    logic [11:0] in_csrb_addr;
    logic [31:0] in_csrb_wdata;
    logic        halt;
    logic        pc_wen;
    logic        csra_wen;
    logic        csrb_wen;
    logic        gpr_wen;
    logic [31:0] new_pc;
    logic [11:0] CSR_waddra;
    logic [31:0] new_CSRa;
    logic [11:0] CSR_waddrb;
    logic [31:0] new_CSRb;
    logic [4:0]  GPR_waddr;
    logic [31:0] new_GPR;
    logic [63:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    wb_commit_unit #(
        .DEPTH (4),
        .CNT_W (64)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc_next    (in_pc_next),
        .in_gpr_wen    (in_gpr_wen),
        .in_gpr_waddr  (in_gpr_waddr),
        .in_gpr_wdata  (in_gpr_wdata),
        .in_csra_wen   (in_csra_wen),
        .in_csra_addr  (in_csra_addr),
        .in_csra_wdata (in_csra_wdata),
        .in_csrb_wen   (in_csrb_wen),
        .in_csrb_addr  (in_csrb_addr),
        .in_csrb_wdata (in_csrb_wdata),
        .halt          (halt),
        .pc_wen        (pc_wen),
        .csra_wen      (csra_wen),
        .csrb_wen      (csrb_wen),
        .gpr_wen       (gpr_wen),
        .new_pc        (new_pc),
        .CSR_waddra    (CSR_waddra),
        .new_CSRa      (new_CSRa),
        .CSR_waddrb    (CSR_waddrb),
        .new_CSRb      (new_CSRb),
        .GPR_waddr     (GPR_waddr),
        .new_GPR       (new_GPR),
        .commit_cnt    (commit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        in_valid      = 1'b0;
        in_pc_next    = '0;
        in_gpr_wen    = 1'b0;
        in_gpr_waddr  = '0;
        in_gpr_wdata  = '0;
        in_csra_wen   = 1'b0;
        in_csra_addr  = '0;
        in_csra_wdata = '0;
        in_csrb_wen   = 1'b0;
        in_csrb_addr  = '0;
        in_csrb_wdata = '0;
    endtask

    task automatic chk_wens(input string tag, input logic [3:0] exp);
        chk(tag, {60'd0, pc_wen, gpr_wen, csra_wen, csrb_wen}, {60'd0, exp});
    endtask

    initial begin
        clr_in();
        halt  = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("rst_wens", {60'd0, pc_wen, gpr_wen, csra_wen, csrb_wen}, 64'd0);
        chk("rst_cnt", commit_cnt, 64'd0);
        chk("rst_pc", {32'd0, new_pc}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        // Single instruction writing x5.
        in_valid     = 1'b1;
        in_pc_next   = 32'h8000_0004;
        in_gpr_wen   = 1'b1;
        in_gpr_waddr = 5'd5;
        in_gpr_wdata = 32'hDEAD_BEEF;
        step();
        clr_in();
        chk_wens("single_lat_wens", 4'b0000);
        step();
        chk_wens("single_wens", 4'b1100);
        chk("single_gaddr", {59'd0, GPR_waddr}, 64'd5);
        chk("single_gdata", {32'd0, new_GPR}, 64'hDEAD_BEEF);
        chk("single_pc", {32'd0, new_pc}, 64'h8000_0004);
        chk("single_cnt", commit_cnt, 64'd1);
        step();
        chk_wens("single_after_wens", 4'b0000);
        chk("single_hold_gdata", {32'd0, new_GPR}, 64'hDEAD_BEEF);
        chk("single_hold_cnt", commit_cnt, 64'd1);

        // Write to x0 is suppressed.
        in_valid     = 1'b1;
        in_pc_next   = 32'h8000_0008;
        in_gpr_wen   = 1'b1;
        in_gpr_waddr = 5'd0;
        in_gpr_wdata = 32'h0000_1234;
        step();
        clr_in();
        step();
        chk_wens("x0_wens", 4'b1000);
        chk("x0_pc", {32'd0, new_pc}, 64'h8000_0008);
        chk("x0_cnt", commit_cnt, 64'd2);

        // Same-address CSR clash: port B wins.
        in_valid      = 1'b1;
        in_pc_next    = 32'h8000_000C;
        in_csra_wen   = 1'b1;
        in_csra_addr  = 12'h341;
        in_csra_wdata = 32'h11;
        in_csrb_wen   = 1'b1;
        in_csrb_addr  = 12'h341;
        in_csrb_wdata = 32'h22;
        step();
        clr_in();
        step();
        chk_wens("csr_clash_wens", 4'b1001);
        chk("csr_clash_baddr", {52'd0, CSR_waddrb}, 64'h341);
        chk("csr_clash_bdata", {32'd0, new_CSRb}, 64'h22);
        chk("csr_clash_cnt", commit_cnt, 64'd3);

        // Distinct CSR addresses: both ports write.
        in_valid      = 1'b1;
        in_pc_next    = 32'h8000_0010;
        in_csra_wen   = 1'b1;
        in_csra_addr  = 12'h300;
        in_csra_wdata = 32'hA5;
        in_csrb_wen   = 1'b1;
        in_csrb_addr  = 12'h342;
        in_csrb_wdata = 32'h5A;
        step();
        clr_in();
        step();
        chk_wens("csr_both_wens", 4'b1011);
        chk("csr_both_aaddr", {52'd0, CSR_waddra}, 64'h300);
        chk("csr_both_adata", {32'd0, new_CSRa}, 64'hA5);
        chk("csr_both_bdata", {32'd0, new_CSRb}, 64'h5A);
        chk("csr_both_cnt", commit_cnt, 64'd4);

        // Halt while pushing five entries; the fifth must wait for space.
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_ready_pre", {63'd0, in_ready}, 64'd1);
            in_valid     = 1'b1;
            in_pc_next   = 32'h1000 + 32'(i * 4);
            in_gpr_wen   = 1'b1;
            in_gpr_waddr = 5'(i + 1);
            in_gpr_wdata = 32'(i);
            step();
            chk_wens("halt_no_pop", 4'b0000);
        end
        in_pc_next   = 32'h1010;
        in_gpr_waddr = 5'd5;
        in_gpr_wdata = 32'd4;
        chk("halt_full_ready", {63'd0, in_ready}, 64'd0);
        step();
        step();
        chk("halt_still_full", {63'd0, in_ready}, 64'd0);
        chk("halt_cnt", commit_cnt, 64'd4);
        halt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) clr_in();
            chk_wens("drain_wens", 4'b1100);
            chk("drain_pc", {32'd0, new_pc}, 64'h1000 + 64'(k * 4));
            chk("drain_gaddr", {59'd0, GPR_waddr}, 64'(k + 1));
            chk("drain_cnt", commit_cnt, 64'(5 + k));
        end
        step();
        chk_wens("drain_done_wens", 4'b0000);
        chk("drain_done_ready", {63'd0, in_ready}, 64'd1);

        // Streaming: one push and one commit per cycle.
        for (int i = 0; i < 100; i++) begin
            in_valid   = 1'b1;
            in_pc_next = 32'h2000 + 32'(i * 4);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
            step();
            if (i > 0) begin
                chk("stream_pcwen", {63'd0, pc_wen}, 64'd1);
                chk("stream_pc", {32'd0, new_pc}, 64'h2000 + 64'((i - 1) * 4));
            end
        end
        clr_in();
        step();
        chk("stream_last_pc", {32'd0, new_pc}, 64'h2000 + 64'(99 * 4));
        chk("stream_cnt", commit_cnt, 64'd109);
        step();
        chk_wens("stream_idle_wens", 4'b0000);

        // Reset with three entries buffered discards them.
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid     = 1'b1;
            in_pc_next   = 32'h3000 + 32'(i * 4);
            in_gpr_wen   = 1'b1;
            in_gpr_waddr = 5'd7;
            in_gpr_wdata = 32'h77;
            step();
        end
        clr_in();
        reset = 1'b1;
        #2;
        chk("mrst_pc", {32'd0, new_pc}, 64'd0);
        chk("mrst_cnt", commit_cnt, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd1);
        step();
        reset = 1'b0;
        halt  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_wens("mrst_no_strobe", 4'b0000);
            chk("mrst_cnt_hold", commit_cnt, 64'd0);
        end
        chk("mrst_gpr", {32'd0, new_GPR}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
